// File: rtl/store_buffer.sv
// M-stage store buffer: selects forwarded or raw store data, aligns it into a
// word plus byte strobes, queues it in a FIFO and drains it to data memory.
package store_buffer_pkg;
  typedef enum logic [1:0] {
    MEM_NONE  = 2'b00,
    MEM_READ  = 2'b01,
    MEM_WRITE = 2'b10
  } memaccess_t;
endpackage

module store_buffer
  import store_buffer_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en_m,
  input  memaccess_t        memaccess_m,
  input  logic [2:0]        funct3_m,
  input  logic [ADDR_W-1:0] addr_m,
  input  logic [31:0]       rs2_data_m,
  input  logic [31:0]       result_w,
  input  logic              forward_m,
  output logic              stall_sb,
  output logic              store_fault,
  output logic              sb_empty,
  output logic              dmem_req,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);

  logic [PTR_W-1:0]  head, tail;
  logic [PTR_W:0]    count;
  logic [DEPTH-1:0]  ent_valid;
  logic [ADDR_W-1:0] ent_addr  [DEPTH];
  logic [31:0]       ent_wdata [DEPTH];
  logic [3:0]        ent_be    [DEPTH];

  logic [31:0] st_data;
  logic [31:0] al_wdata;
  logic [3:0]  al_be;
  logic        al_fault;
  logic        is_store, is_load;
  logic        full, load_hit;
  logic        enq, deq;

  // Store-data select and alignment.
  always_comb begin
    st_data  = forward_m ? result_w : rs2_data_m;
    al_wdata = '0;
    al_be    = '0;
    al_fault = 1'b0;
    case (funct3_m)
      3'b000: begin
        al_wdata = {4{st_data[7:0]}};
        al_be    = 4'b0001 << addr_m[1:0];
      end
      3'b001: begin
        al_wdata = {2{st_data[15:0]}};
        al_be    = 4'b0011 << {addr_m[1], 1'b0};
        al_fault = addr_m[0];
      end
      3'b010: begin
        al_wdata = st_data;
        al_be    = 4'b1111;
        al_fault = (addr_m[1:0] != 2'b00);
      end
      default: al_fault = 1'b1;
    endcase
  end

  // Word-granular compare against every pending entry; strobes ignored.
  always_comb begin
    load_hit = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (ent_valid[i] && (ent_addr[i][ADDR_W-1:2] == addr_m[ADDR_W-1:2]))
        load_hit = 1'b1;
    end
  end

  assign is_store    = en_m && (memaccess_m == MEM_WRITE);
  assign is_load     = en_m && (memaccess_m == MEM_READ);
  assign full        = (count == FULL_CNT);
  assign store_fault = is_store && al_fault;
  assign stall_sb    = (is_store && !al_fault && full) || (is_load && load_hit);
  assign enq         = is_store && !al_fault && !full;
  assign deq         = dmem_req && dmem_ack;

  assign sb_empty   = (count == '0);
  assign dmem_req   = ent_valid[head];
  assign dmem_addr  = ent_addr[head];
  assign dmem_wdata = ent_wdata[head];
  assign dmem_be    = ent_be[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head      <= '0;
      tail      <= '0;
      count     <= '0;
      ent_valid <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        ent_addr[i]  <= '0;
        ent_wdata[i] <= '0;
        ent_be[i]    <= '0;
      end
    end else begin
      if (enq) begin
        ent_addr[tail]  <= {addr_m[ADDR_W-1:2], 2'b00};
        ent_wdata[tail] <= al_wdata;
        ent_be[tail]    <= al_be;
        ent_valid[tail] <= 1'b1;
        tail            <= tail + 1'b1;
      end
      if (deq) begin
        ent_valid[head] <= 1'b0;
        head            <= head + 1'b1;
      end
      case ({enq, deq})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: table-driven alignment vectors plus
// hand-written full, load-conflict and reset sequences; writes go via a scoreboard.
module tb_store_buffer;
  import store_buffer_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_m;
  memaccess_t  memaccess_m;
  logic [2:0]  funct3_m;
  logic [31:0] addr_m;
  logic [31:0] rs2_data_m;
  logic [31:0] result_w;
  logic        forward_m;
  logic        stall_sb, store_fault, sb_empty;
  logic        dmem_req;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;

  store_buffer #(.DEPTH(4), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .en_m(en_m), .memaccess_m(memaccess_m),
    .funct3_m(funct3_m), .addr_m(addr_m), .rs2_data_m(rs2_data_m),
    .result_w(result_w), .forward_m(forward_m), .stall_sb(stall_sb),
    .store_fault(store_fault), .sb_empty(sb_empty), .dmem_req(dmem_req),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
    .dmem_ack(dmem_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] rs2;
    logic [31:0] res;
    logic        fwd;
    logic        fault;
    logic [31:0] e_addr;
    logic [31:0] e_wdata;
    logic [3:0]  e_be;
  } vec_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } wr_t;

  wr_t exp_q[$];
  int  n_chk  = 0;
  int  n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every accepted memory write must match the oldest expected one.
  always @(negedge clk) begin
    if (rst_n && dmem_req && dmem_ack) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_write: got addr %h expected no write at %0t", dmem_addr, $time);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_addr", dmem_addr, e.addr);
        check("wr_wdata", dmem_wdata, e.wdata);
        check("wr_be", {28'd0, dmem_be}, {28'd0, e.be});
      end
    end
  end

  task automatic drive(input logic en, input memaccess_t acc, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] rs2,
                       input logic [31:0] res, input logic fwd);
    en_m = en; memaccess_m = acc; funct3_m = f3; addr_m = addr;
    rs2_data_m = rs2; result_w = res; forward_m = fwd;
  endtask

  task automatic idle();
    drive(1'b0, MEM_NONE, 3'b000, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] w, input logic [3:0] b);
    wr_t e;
    e.addr = a; e.wdata = w; e.be = b;
    exp_q.push_back(e);
  endtask

  task automatic drain();
    int c;
    dmem_ack = 1'b1;
    c = 0;
    while (!sb_empty && c < 20) begin
      next_cycle();
      c++;
    end
    @(negedge clk);
    check("drain_empty", {31'd0, sb_empty}, 32'd1);
    check("drain_sb_left", exp_q.size(), 32'd0);
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{3'b010, 32'h100, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 32'h100, 32'hDEADBEEF, 4'b1111};
    vecs[1] = '{3'b000, 32'h203, 32'hFFFFFFFF, 32'h000000A5, 1'b1, 1'b0, 32'h200, 32'hA5A5A5A5, 4'b1000};
    vecs[2] = '{3'b001, 32'h202, 32'h00001234, 32'hFFFF0000, 1'b0, 1'b0, 32'h200, 32'h12341234, 4'b1100};
    vecs[3] = '{3'b001, 32'h201, 32'h00001234, 32'h0,        1'b0, 1'b1, 32'h0,   32'h0,        4'b0000};
    vecs[4] = '{3'b010, 32'h102, 32'h11111111, 32'h0,        1'b0, 1'b1, 32'h0,   32'h0,        4'b0000};
    vecs[5] = '{3'b011, 32'h100, 32'h22222222, 32'h0,        1'b0, 1'b1, 32'h0,   32'h0,        4'b0000};
    vecs[6] = '{3'b000, 32'h101, 32'h00000077, 32'hFFFFFFFF, 1'b0, 1'b0, 32'h100, 32'h77777777, 4'b0010};
    vecs[7] = '{3'b001, 32'h200, 32'h0,        32'h0000ABCD, 1'b1, 1'b0, 32'h200, 32'hABCDABCD, 4'b0011};
    vecs[8] = '{3'b100, 32'h300, 32'h33333333, 32'h0,        1'b0, 1'b1, 32'h0,   32'h0,        4'b0000};

    rst_n = 1'b0;
    dmem_ack = 1'b0;
    idle();
    @(negedge clk);
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_empty", {31'd0, sb_empty}, 32'd1);
    check("rst_be", {28'd0, dmem_be}, 32'd0);
    check("rst_wdata", dmem_wdata, 32'd0);
    check("rst_addr", dmem_addr, 32'd0);
    next_cycle();
    rst_n = 1'b1;

    // Alignment / fault table, one store at a time with ack held high.
    for (int i = 0; i < 9; i++) begin
      dmem_ack = 1'b1;
      drive(1'b1, MEM_WRITE, vecs[i].f3, vecs[i].addr, vecs[i].rs2, vecs[i].res, vecs[i].fwd);
      @(negedge clk);
      check("vec_fault", {31'd0, store_fault}, {31'd0, vecs[i].fault});
      check("vec_stall", {31'd0, stall_sb}, 32'd0);
      if (!vecs[i].fault) push(vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_be);
      next_cycle();
      idle();
      @(negedge clk);
      check("vec_req", {31'd0, dmem_req}, {31'd0, !vecs[i].fault});
      next_cycle();
      @(negedge clk);
      check("vec_empty", {31'd0, sb_empty}, 32'd1);
      next_cycle();
    end

    // Back-to-back stores with ack high: simultaneous enqueue and dequeue.
    dmem_ack = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, MEM_WRITE, 3'b010, 32'h600 + 32'(i * 4), 32'hC0DE0000 + 32'(i), 32'h0, 1'b0);
      @(negedge clk);
      check("b2b_stall", {31'd0, stall_sb}, 32'd0);
      push(32'h600 + 32'(i * 4), 32'hC0DE0000 + 32'(i), 4'b1111);
      next_cycle();
    end
    idle();
    drain();

    // Fill with ack low; fifth store stalls until one cycle after an ack pulse.
    next_cycle();
    dmem_ack = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, MEM_WRITE, 3'b010, 32'h400 + 32'(i * 4), 32'hF00D0000 + 32'(i), 32'h0, 1'b0);
      @(negedge clk);
      check("fill_stall", {31'd0, stall_sb}, {31'd0, i == 4});
      if (i < 4) push(32'h400 + 32'(i * 4), 32'hF00D0000 + 32'(i), 4'b1111);
      next_cycle();
    end
    dmem_ack = 1'b1;
    @(negedge clk);
    check("full_ack_stall", {31'd0, stall_sb}, 32'd1);
    next_cycle();
    dmem_ack = 1'b0;
    @(negedge clk);
    check("full_after_stall", {31'd0, stall_sb}, 32'd0);
    push(32'h410, 32'hF00D0004, 4'b1111);
    next_cycle();
    idle();
    drain();

    // Load conflict against a pending word.
    next_cycle();
    dmem_ack = 1'b0;
    drive(1'b1, MEM_WRITE, 3'b010, 32'h300, 32'h5A5A5A5A, 32'h0, 1'b0);
    push(32'h300, 32'h5A5A5A5A, 4'b1111);
    next_cycle();
    drive(1'b1, MEM_READ, 3'b010, 32'h302, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("ld_hit_stall", {31'd0, stall_sb}, 32'd1);
    next_cycle();
    drive(1'b1, MEM_READ, 3'b010, 32'h304, 32'h0, 32'h0, 1'b0);
    @(negedge clk);
    check("ld_miss_stall", {31'd0, stall_sb}, 32'd0);
    next_cycle();
    drive(1'b1, MEM_READ, 3'b010, 32'h302, 32'h0, 32'h0, 1'b0);
    dmem_ack = 1'b1;
    @(negedge clk);
    check("ld_hit_ack_stall", {31'd0, stall_sb}, 32'd1);
    next_cycle();
    @(negedge clk);
    check("ld_after_deq_stall", {31'd0, stall_sb}, 32'd0);
    next_cycle();
    idle();

    // Ack with nothing pending is ignored.
    repeat (3) begin
      @(negedge clk);
      check("idle_ack_empty", {31'd0, sb_empty}, 32'd1);
      next_cycle();
    end

    // Asynchronous reset discards pending stores.
    dmem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, MEM_WRITE, 3'b010, 32'h500 + 32'(i * 4), 32'hBAD00000 + 32'(i), 32'h0, 1'b0);
      next_cycle();
    end
    idle();
    @(negedge clk);
    check("pre_rst_req", {31'd0, dmem_req}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_req", {31'd0, dmem_req}, 32'd0);
    check("async_rst_empty", {31'd0, sb_empty}, 32'd1);
    next_cycle();
    rst_n = 1'b1;
    dmem_ack = 1'b1;
    repeat (5) begin
      @(negedge clk);
      check("post_rst_req", {31'd0, dmem_req}, 32'd0);
      next_cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
